// File: rtl/mips8_pkg.sv
// Definitions shared between operand fetch and the ALU: function codes and the
// default datapath and register-index widths.
package mips8_pkg;

  localparam int MIPS_DW = 8;
  localparam int MIPS_AW = 3;

  typedef enum logic [2:0] {
    FUNC_NONE = 3'd0,
    FUNC_ADD  = 3'd1,
    FUNC_SUB  = 3'd2,
    FUNC_AND  = 3'd3,
    FUNC_OR   = 3'd4,
    FUNC_XOR  = 3'd5
  } func_e;

endpackage

// File: rtl/regfile8.sv
// Register file with two asynchronous read ports and one synchronous write
// port; register 0 is hard-wired to zero.
module regfile8
  import mips8_pkg::*;
#(
  parameter int DW = MIPS_DW,
  parameter int AW = MIPS_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] r_mem [NREG];

  // Register storage; writes to index 0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= {DW{1'b0}};
      end
    end else if (i_we && (i_waddr != {AW{1'b0}})) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == {AW{1'b0}}) ? {DW{1'b0}} : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == {AW{1'b0}}) ? {DW{1'b0}} : r_mem[i_raddr2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register read with write-back bypass, a per-register
// pending scoreboard for hazards, the flag register and the output bundle.
module operand_fetch
  import mips8_pkg::*;
#(
  parameter int DW = MIPS_DW,
  parameter int AW = MIPS_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic [2:0]    in_func,
  input  logic          in_set_flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] op1,
  output logic [DW-1:0] op2,
  output logic [2:0]    func,
  output logic [AW-1:0] out_rd,
  output logic          out_set_flags,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          wb_set_flags,
  input  logic          wb_zero,
  input  logic          wb_sign,
  input  logic          wb_ovf,
  output logic          flag_zero,
  output logic          flag_sign,
  output logic          flag_ovf
);

  localparam int NREG = 2 ** AW;
  localparam logic [NREG-1:0] BIT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [DW-1:0]   w_rd1, w_rd2, w_src1, w_src2;
  logic            w_byp1, w_byp2, w_hazard, w_accept;
  logic [NREG-1:0] w_clr_mask, w_set_mask, w_pending_nxt;
  logic [NREG-1:0] r_pending;
  logic            r_out_valid, r_set_flags;
  logic [DW-1:0]   r_op1, r_op2;
  logic [2:0]      r_func;
  logic [AW-1:0]   r_rd;
  logic            r_fz, r_fs, r_fo;

  regfile8 #(.DW(DW), .AW(AW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (wb_en),
    .i_waddr  (wb_rd),
    .i_wdata  (wb_data),
    .i_raddr1 (in_rs1),
    .i_raddr2 (in_rs2),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  // A write-back landing this cycle both supplies the value and clears the hazard.
  assign w_byp1 = wb_en && (wb_rd == in_rs1) && (in_rs1 != {AW{1'b0}});
  assign w_byp2 = wb_en && (wb_rd == in_rs2) && (in_rs2 != {AW{1'b0}});
  assign w_src1 = w_byp1 ? wb_data : w_rd1;
  assign w_src2 = in_use_imm ? in_imm : (w_byp2 ? wb_data : w_rd2);

  assign w_hazard = (r_pending[in_rs1] && !w_byp1) ||
                    (!in_use_imm && r_pending[in_rs2] && !w_byp2);
  assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && in_ready;

  // Set is applied after clear so a same-cycle issue to the register wins.
  assign w_clr_mask    = wb_en ? (BIT0 << wb_rd) : {NREG{1'b0}};
  assign w_set_mask    = (w_accept && (in_rd != {AW{1'b0}})) ? (BIT0 << in_rd) : {NREG{1'b0}};
  assign w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~BIT0;

  // Scoreboard of registers with an outstanding result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= {NREG{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Output bundle: load on accept, drain when taken, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_op1       <= {DW{1'b0}};
      r_op2       <= {DW{1'b0}};
      r_func      <= 3'd0;
      r_rd        <= {AW{1'b0}};
      r_set_flags <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_op1       <= w_src1;
      r_op2       <= w_src2;
      r_func      <= in_func;
      r_rd        <= in_rd;
      r_set_flags <= in_set_flags;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Architectural flags updated by the ALU write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fz <= 1'b0;
      r_fs <= 1'b0;
      r_fo <= 1'b0;
    end else if (wb_en && wb_set_flags) begin
      r_fz <= wb_zero;
      r_fs <= wb_sign;
      r_fo <= wb_ovf;
    end
  end

  assign out_valid     = r_out_valid;
  assign op1           = r_op1;
  assign op2           = r_op2;
  assign func          = r_func;
  assign out_rd        = r_rd;
  assign out_set_flags = r_set_flags;
  assign flag_zero     = r_fz;
  assign flag_sign     = r_fs;
  assign flag_ovf      = r_fo;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and random stimulus for operand_fetch, checked against an
// architectural model of registers, pending results, flags and the bundle.
module tb_operand_fetch;
  import mips8_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, in_use_imm, in_set_flags;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic [DW-1:0] in_imm;
  logic [2:0]    in_func;
  logic          out_valid, out_ready, out_set_flags;
  logic [DW-1:0] op1, op2;
  logic [2:0]    func;
  logic [AW-1:0] out_rd;
  logic          wb_en, wb_set_flags, wb_zero, wb_sign, wb_ovf;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          flag_zero, flag_sign, flag_ovf;

  operand_fetch #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_func(in_func), .in_set_flags(in_set_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .func(func), .out_rd(out_rd), .out_set_flags(out_set_flags),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_set_flags(wb_set_flags), .wb_zero(wb_zero), .wb_sign(wb_sign), .wb_ovf(wb_ovf),
    .flag_zero(flag_zero), .flag_sign(flag_sign), .flag_ovf(flag_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model state
  logic [DW-1:0] m_regs [8];
  logic          m_pend [8];
  logic          m_valid, m_sf, m_fz, m_fs, m_fo;
  logic [DW-1:0] m_op1, m_op2;
  logic [2:0]    m_func;
  logic [AW-1:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 3'd0) return 8'h00;
    if (wb_en && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic m_ready();
    logic busy1, busy2;
    busy1 = m_pend[in_rs1] && !(wb_en && wb_rd == in_rs1);
    busy2 = !in_use_imm && m_pend[in_rs2] && !(wb_en && wb_rd == in_rs2);
    return (!m_valid || out_ready) && !busy1 && !busy2;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 8'h00;
      m_pend[i] = 1'b0;
    end
    m_valid = 1'b0; m_op1 = 8'h00; m_op2 = 8'h00; m_func = 3'd0; m_rd = 3'd0;
    m_sf = 1'b0; m_fz = 1'b0; m_fs = 1'b0; m_fo = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_valid);
    chk({tag, ".op1"}, op1, m_op1);
    chk({tag, ".op2"}, op2, m_op2);
    chk({tag, ".func"}, func, m_func);
    chk({tag, ".out_rd"}, out_rd, m_rd);
    chk({tag, ".out_set_flags"}, out_set_flags, m_sf);
    chk({tag, ".flags"}, {flag_zero, flag_sign, flag_ovf}, {m_fz, m_fs, m_fo});
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rs1 = 3'd0; in_rs2 = 3'd0; in_rd = 3'd0; in_imm = 8'h00;
    in_use_imm = 1'b0; in_func = 3'd0; in_set_flags = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = 3'd0; wb_data = 8'h00; wb_set_flags = 1'b0;
    wb_zero = 1'b0; wb_sign = 1'b0; wb_ovf = 1'b0;
  endtask

  // One clock: check in_ready mid-cycle, advance the model at the edge, then check outputs.
  task automatic cycle(input string tag);
    logic rdy, acc;
    logic [DW-1:0] n_op1, n_op2;
    @(negedge clk);
    rdy = m_ready();
    chk({tag, ".in_ready"}, in_ready, rdy);
    acc = in_valid && rdy;
    n_op1 = m_read(in_rs1);
    n_op2 = in_use_imm ? in_imm : m_read(in_rs2);
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1; m_op1 = n_op1; m_op2 = n_op2;
      m_func = in_func; m_rd = in_rd; m_sf = in_set_flags;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en && wb_rd != 3'd0) m_regs[wb_rd] = wb_data;
    if (wb_en) m_pend[wb_rd] = 1'b0;
    if (acc && in_rd != 3'd0) m_pend[in_rd] = 1'b1;
    if (wb_en && wb_set_flags) begin
      m_fz = wb_zero; m_fs = wb_sign; m_fo = wb_ovf;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] held_op1, held_op2;

  initial begin
    idle();
    model_clear();
    rst_n = 1'b0;
    #2;
    do_reset("reset");
    idle();
    cycle("first_after_reset");

    // Immediate operand with r0 source
    in_valid = 1'b1; in_rs1 = 3'd0; in_use_imm = 1'b1; in_imm = 8'h7F; in_func = FUNC_ADD;
    cycle("imm_add");
    chk("imm_add.op2_const", op2, 8'h7F);
    chk("imm_add.func_const", func, 3'd1);

    // Same-cycle write-back bypass to both sources
    idle();
    in_valid = 1'b1; in_rs1 = 3'd3; in_rs2 = 3'd3; in_func = FUNC_SUB;
    wb_en = 1'b1; wb_rd = 3'd3; wb_data = 8'h5A;
    cycle("bypass");
    chk("bypass.op1_const", op1, 8'h5A);
    chk("bypass.op2_const", op2, 8'h5A);
    idle();
    in_valid = 1'b1; in_rs1 = 3'd3; in_rs2 = 3'd0; in_func = 3'd7;
    cycle("stored_r3");

    // RAW hazard on r2 resolved by its write-back
    idle();
    in_valid = 1'b1; in_rd = 3'd2; in_use_imm = 1'b1; in_imm = 8'h01; in_func = FUNC_ADD;
    cycle("issue_rd2");
    idle();
    in_valid = 1'b1; in_rs1 = 3'd2; in_use_imm = 1'b1; in_imm = 8'h02; in_func = FUNC_XOR;
    cycle("stall1");
    cycle("stall2");
    chk("stall.in_ready_const", in_ready, 1'b0);
    wb_en = 1'b1; wb_rd = 3'd2; wb_data = 8'h11;
    cycle("hazard_release");
    chk("hazard_release.op1_const", op1, 8'h11);

    // Back-pressure holds the bundle, then back-to-back loads
    idle();
    in_valid = 1'b1; in_rs1 = 3'd3; in_func = FUNC_AND; in_set_flags = 1'b1;
    cycle("bp_load");
    held_op1 = op1; held_op2 = op2;
    out_ready = 1'b0; in_rs1 = 3'd0; in_use_imm = 1'b1; in_imm = 8'h22; in_func = FUNC_OR;
    in_set_flags = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      chk("bp_hold.op1_stable", op1, held_op1);
      chk("bp_hold.op2_stable", op2, held_op2);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    in_imm = 8'h33; in_func = 3'd6;
    cycle("bp_b2b");
    chk("bp_b2b.valid_const", out_valid, 1'b1);
    chk("bp_b2b.op2_const", op2, 8'h33);

    // Flags load, hold, and r0 ignores writes
    idle();
    wb_en = 1'b1; wb_rd = 3'd0; wb_data = 8'hFF; wb_set_flags = 1'b1;
    wb_zero = 1'b1; wb_sign = 1'b0; wb_ovf = 1'b1;
    cycle("flags_set");
    chk("flags_set.const", {flag_zero, flag_sign, flag_ovf}, 3'b101);
    wb_set_flags = 1'b0; wb_zero = 1'b0; wb_sign = 1'b1; wb_ovf = 1'b0;
    in_valid = 1'b1; in_rs1 = 3'd0; in_rs2 = 3'd0;
    cycle("flags_hold_r0_bypass");
    wb_en = 1'b0;
    cycle("r0_read");
    chk("r0_read.op1_const", op1, 8'h00);

    // Reset with a held bundle and a pending r4
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_rd = 3'd4; in_use_imm = 1'b1; in_imm = 8'h44; in_func = FUNC_ADD;
    cycle("pre_reset_issue");
    in_valid = 1'b0;
    cycle("pre_reset_hold");
    do_reset("mid_reset");
    idle();
    in_valid = 1'b1; in_rs1 = 3'd4; in_rs2 = 3'd4;
    cycle("post_reset_r4");
    chk("post_reset_r4.op1_const", op1, 8'h00);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid     = ($urandom % 4) != 0;
      in_rs1       = AW'($urandom);
      in_rs2       = AW'($urandom);
      in_rd        = AW'($urandom);
      in_imm       = DW'($urandom);
      in_use_imm   = ($urandom % 3) == 0;
      in_func      = 3'($urandom);
      in_set_flags = 1'($urandom);
      out_ready    = ($urandom % 4) != 0;
      wb_en        = 1'($urandom);
      wb_rd        = AW'($urandom);
      wb_data      = DW'($urandom);
      wb_set_flags = 1'($urandom);
      wb_zero      = 1'($urandom);
      wb_sign      = 1'($urandom);
      wb_ovf       = 1'($urandom);
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
